// File: rtl/binary_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional two's-complement input: the magnitude is converted and the sign is reported on neg_o.
module binary_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  neg_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  // ceil(WIDTH * log10(2)), evaluated in fixed point
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("binary_bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < MIN_DIGITS) begin : g_digits_chk
    $error("binary_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    scr_q;
  logic             sign_q;
  logic             busy_q;
  logic             done_q;
  logic [BW-1:0]    bcd_q;
  logic             neg_q;

  logic             bin_neg;
  logic [WIDTH-1:0] bin_mag;
  logic [BW-1:0]    scr_adj;
  logic [BW-1:0]    scr_d;
  logic [WIDTH-1:0] mag_d;

  // Plain unsigned negate: the most-negative input yields its true magnitude.
  assign bin_neg = (SIGNED != 0) && bin_i[WIDTH-1];
  assign bin_mag = bin_neg ? (~bin_i + WIDTH'(1)) : bin_i;

  always_comb begin
    scr_adj = scr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scr_q[4*d +: 4] >= 4'd5) begin
        scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
      end
    end
  end

  assign {scr_d, mag_d} = {scr_adj, mag_q} << 1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) begin
            bcd_q  <= scr_q;
            neg_q  <= sign_q;
            done_q <= 1'b1;
          end
          if (start_i) begin
            state_q <= S_SHIFT;
            busy_q  <= 1'b1;
            mag_q   <= bin_mag;
            sign_q  <= bin_neg;
            scr_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scr_q <= scr_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;
  assign neg_o  = neg_q;

endmodule

// File: tb/tb_binary_bcd_seq.sv
// Bench for binary_bcd_seq: cycle model for the default instance plus directed checks
// on signed, 16-bit and exhaustive 10-bit instances.
module tb_binary_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start_a, busy_a, done_a, neg_a;
  logic [7:0]  bin_a;
  logic [11:0] bcd_a;
  logic        start_s, busy_s, done_s, neg_s;
  logic [7:0]  bin_s;
  logic [11:0] bcd_s;
  logic        start_w, busy_w, done_w, neg_w;
  logic [15:0] bin_w;
  logic [19:0] bcd_w;
  logic        start_t, busy_t, done_t, neg_t;
  logic [9:0]  bin_t;
  logic [15:0] bcd_t;

  binary_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .bin_i(bin_a),
    .busy_o(busy_a), .done_o(done_a), .bcd_o(bcd_a), .neg_o(neg_a));
  binary_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s), .bin_i(bin_s),
    .busy_o(busy_s), .done_o(done_s), .bcd_o(bcd_s), .neg_o(neg_s));
  binary_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_w (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_w), .bin_i(bin_w),
    .busy_o(busy_w), .done_o(done_w), .bcd_o(bcd_w), .neg_o(neg_w));
  binary_bcd_seq #(.WIDTH(10), .DIGITS(4), .SIGNED(0)) u_t (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_t), .bin_i(bin_t),
    .busy_o(busy_t), .done_o(done_t), .bcd_o(bcd_t), .neg_o(neg_t));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] to_bcd(int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Latency model of the default instance: cycles left until the result appears.
  int          m_left = 0;
  logic [7:0]  m_val  = '0;
  logic [11:0] m_bcd  = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0;
      m_bcd  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_bcd <= 12'(to_bcd(32'(m_val)));
      if (m_left <= 1 && start_a) begin
        m_val  <= bin_a;
        m_left <= 9;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy_a, m_left >= 2);
      chk("model_done", done_a, m_done);
      chk("model_bcd",  bcd_a,  m_bcd);
      chk("model_neg",  neg_a,  1'b0);
    end
  end

  task automatic conv_a(input logic [7:0] v, output logic [11:0] r, output int lat);
    lat = -1; r = '0;
    start_a = 1'b1; bin_a = v;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a) begin lat = n - 1; r = bcd_a; break; end
    end
    if (lat < 0) chk("timeout_a", done_a, 1'b1);
  endtask

  task automatic conv_s(input logic [7:0] v, output logic [11:0] r, output logic ng);
    int got;
    got = 0; r = '0; ng = 1'b0;
    start_s = 1'b1; bin_s = v;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (done_s) begin got = 1; r = bcd_s; ng = neg_s; break; end
    end
    if (got == 0) chk("timeout_s", done_s, 1'b1);
  endtask

  task automatic conv_w(input logic [15:0] v, output logic [19:0] r, output int lat);
    lat = -1; r = '0;
    start_w = 1'b1; bin_w = v;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start_w = 1'b0;
      if (done_w) begin lat = n - 1; r = bcd_w; break; end
    end
    if (lat < 0) chk("timeout_w", done_w, 1'b1);
  endtask

  task automatic conv_t(input logic [9:0] v, output logic [15:0] r, output int lat);
    lat = -1; r = '0;
    start_t = 1'b1; bin_t = v;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start_t = 1'b0;
      if (done_t) begin lat = n - 1; r = bcd_t; break; end
    end
    if (lat < 0) chk("timeout_t", done_t, 1'b1);
  endtask

  initial begin
    logic [7:0]  dv [3];
    logic [11:0] dx [3];
    logic [11:0] r8;
    logic [19:0] r16;
    logic [15:0] r10;
    logic        ng;
    int          lat, cnt;

    dv = '{8'd0, 8'd99, 8'd255};
    dx = '{12'h000, 12'h099, 12'h255};
    rst_n = 1'b0;
    start_a = 0; start_s = 0; start_w = 0; start_t = 0;
    bin_a = '0; bin_s = '0; bin_w = '0; bin_t = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_bcd_a", bcd_a, 12'h000);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_s", done_s, 1'b0);
    chk("rst_neg_s", neg_s, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("pin_model", to_bcd(32'(dv[i])), 32'(dx[i]));
      conv_a(dv[i], r8, lat);
      chk("lat_a", lat, 9);
      chk("bcd_a_lit", r8, dx[i]);
      @(negedge clk);
      chk("done_pulse", done_a, 1'b0);
    end

    // back-to-back with start held high
    start_a = 1'b1; bin_a = 8'd128;
    @(negedge clk);
    bin_a = 8'd37;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (done_a) begin lat = n; break; end
    end
    chk("b2b_first", bcd_a, 12'h128);
    chk("b2b_nogap", busy_a, 1'b1);
    cnt = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_a) begin cnt = n; break; end
    end
    chk("b2b_spacing", cnt, 9);
    chk("b2b_second", bcd_a, 12'h037);
    start_a = 1'b0;
    repeat (12) @(negedge clk);

    // starts while busy are dropped
    start_a = 1'b1; bin_a = 8'd200;
    cnt = 0; r8 = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done_a) begin cnt++; r8 = bcd_a; end
      start_a = (n == 3 || n == 5);
      bin_a   = (n >= 3) ? 8'd5 : 8'd200;
    end
    chk("drop_count", cnt, 1);
    chk("drop_bcd", r8, 12'h200);

    // reset mid-conversion beats a simultaneous start
    start_a = 1'b1; bin_a = 8'd77;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start_a = 1'b1; bin_a = 8'd42;
    @(negedge clk);
    chk("rst_mid_busy", busy_a, 1'b0);
    chk("rst_mid_done", done_a, 1'b0);
    chk("rst_mid_bcd", bcd_a, 12'h000);
    chk("rst_mid_neg", neg_a, 1'b0);
    rst_n = 1'b1; start_a = 1'b0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (done_a) cnt++; end
    chk("rst_no_done", cnt, 0);
    conv_a(8'd42, r8, lat);
    chk("after_rst_bcd", r8, 12'h042);

    // signed instance
    conv_s(8'h80, r8, ng); chk("s80_bcd", r8, 12'h128); chk("s80_neg", ng, 1'b1);
    conv_s(8'hFF, r8, ng); chk("sFF_bcd", r8, 12'h001); chk("sFF_neg", ng, 1'b1);
    conv_s(8'h7F, r8, ng); chk("s7F_bcd", r8, 12'h127); chk("s7F_neg", ng, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic [7:0] v;
      int unsigned mag;
      v = 8'($urandom);
      mag = v[7] ? 256 - int'(v) : int'(v);
      conv_s(v, r8, ng);
      chk("s_rand_bcd", r8, 12'(to_bcd(mag)));
      chk("s_rand_neg", ng, v[7]);
    end

    // 16-bit instance
    conv_w(16'd65535, r16, lat);
    chk("w16_lat", lat, 17);
    chk("w16_max", r16, 20'h65535);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      conv_w(v, r16, lat);
      chk("w16_rand", r16, 20'(to_bcd(32'(v))));
      chk("w16_neg", neg_w, 1'b0);
    end

    // exhaustive 10-bit sweep
    for (int v = 0; v < 1024; v++) begin
      conv_t(10'(v), r10, lat);
      chk("w10_sweep", r10, 16'(to_bcd(v)));
      if (v == 1023) chk("w10_lat", lat, 11);
    end

    // random traffic on the default instance, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start_a = ($urandom_range(3) == 0);
      bin_a   = 8'($urandom);
      rst_n   = ($urandom_range(99) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start_a = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
